capped_div: RTL and testbench
=============================

CAPPED_DIV -- requirements
Module: capped_div

Interface
REQ-001 The module SHALL have parameter FRACT_BITS, default 8, number of fractional bits of the Q8.8 operands and result.
REQ-002 The module SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1, dividend and divisor present.
REQ-005 The module SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 The module SHALL have port a_in, input, 16, signed Q8.8 dividend.
REQ-007 The module SHALL have port b_in, input, 16, signed Q8.8 divisor.
REQ-008 The module SHALL have port out_valid, output, 1, result held and valid.
REQ-009 The module SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 The module SHALL have port q_out, output, 16, signed Q8.8 quotient, capped.
REQ-011 The module SHALL have port overflow, output, 1, result capped at 0x7FFF.
REQ-012 The module SHALL have port underflow_q, output, 1, result capped at 0x8000.
REQ-013 The module SHALL have port div_by_zero, output, 1, divisor was zero.

Function
REQ-014 The block SHALL compute q = (a_in << FRACT_BITS) / b_in, truncated toward zero, then saturated to Q8.8.
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On in_valid & in_ready, the block SHALL register the operand signs, the 24-bit dividend magnitude |a_in|<<8 and the 16-bit divisor magnitude |b_in| (|0x8000| = 32768), then enter CALC.
REQ-017 CALC SHALL perform unsigned restoring division, one quotient bit per cycle MSB first, for exactly 24 cycles counted by a 5-bit counter, then enter DONE.
REQ-018 With the accept cycle as cycle 0, out_valid SHALL first be high in cycle 25.
REQ-019 On entering DONE, the positive-result rule SHALL apply: magnitude > 32767 gives q_out=0x7FFF and overflow=1.
REQ-020 On entering DONE, the negative-result rule SHALL apply: magnitude > 32768 gives q_out=0x8000 and underflow_q=1; magnitude = 32768 gives 0x8000 with no flag.
REQ-021 The result sign SHALL be sign(a) XOR sign(b); a zero magnitude SHALL give 0x0000 with no flags.
REQ-022 If b_in=0 at accept, the block SHALL skip CALC and enter DONE next cycle (out_valid in cycle 1) with div_by_zero=1.
REQ-023 For a divide by zero with a_in>=0, the result SHALL be q_out=0x7FFF and overflow=1.
REQ-024 For a divide by zero with a_in<0, the result SHALL be q_out=0x8000 and underflow_q=1.
REQ-025 In DONE, q_out and the three flags SHALL remain stable until out_valid & out_ready, after which the block SHALL enter IDLE.
REQ-026 in_ready SHALL rise the cycle after the DONE handshake; there SHALL be no accept in the same cycle as a result handshake.
REQ-027 in_valid SHALL be ignored outside IDLE; a_in and b_in SHALL be sampled only at accept.
REQ-028 Flags SHALL be mutually exclusive except that div_by_zero accompanies overflow or underflow_q.

Reset
REQ-029 On rst_n low, at any time including mid-CALC, the block SHALL immediately enter IDLE and abort any operation.
REQ-030 On rst_n low, q_out SHALL be 0x0000; out_valid, overflow, underflow_q and div_by_zero SHALL be 0; the counter SHALL be 0.
REQ-031 in_ready SHALL be 1 from the first cycle after reset deasserts.

Structure
REQ-032 A shared package capped_div_pkg SHALL hold FRACT_BITS, Q8_8_MAX (0x7FFF), Q8_8_MIN (0x8000), ITER_COUNT (24) and the state enum; the capped multiplier SHALL reuse these constants.
REQ-033 The sign/magnitude-to-capped-Q8.8 conversion SHALL be one combinational sub-module, q88_saturate; the divider datapath SHALL stay in capped_div.

Verification
REQ-034 The bench SHALL apply a=0x0300, b=0x0200 and require q_out=0x0180, no flags, out_valid first high in cycle 25.
REQ-035 The bench SHALL apply a=0xFD00, b=0x0200 and require 0xFE80; it SHALL apply a=0xFF00, b=0x0300 and require 0xFFAB (truncation toward zero).
REQ-036 The bench SHALL apply a=0x7F00, b=0x0080 and require 0x7FFF, overflow=1; it SHALL apply a=0x8000, b=0x0100 and require 0x8000, no flag; it SHALL apply a=0x8000, b=0x00FF and require 0x8000, underflow_q=1.
REQ-037 The bench SHALL apply a=0x0100, b=0 and require 0x7FFF, overflow=1, div_by_zero=1 in cycle 1; it SHALL apply a=0xFF00, b=0 and require 0x8000, underflow_q=1, div_by_zero=1.
REQ-038 The bench SHALL hold out_ready=0 for 10 cycles in DONE and require q_out and the flags stable, in_ready=0 and in_valid ignored.
REQ-039 The bench SHALL assert rst_n low at CALC cycle 12 and require all outputs at reset values; the next operation SHALL then complete correctly.

Source files
------------

// File: rtl/capped_div_pkg.sv
// Shared constants and types for the capped Q8.8 arithmetic blocks.
package capped_div_pkg;

    localparam int unsigned FRACT_BITS = 8;
    localparam logic [15:0] Q8_8_MAX   = 16'h7FFF;
    localparam logic [15:0] Q8_8_MIN   = 16'h8000;
    localparam int unsigned ITER_COUNT = 24;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Two's-complement magnitude; 0x8000 maps to 32768 as an unsigned value.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/q88_saturate.sv
// Converts a sign plus unsigned quotient magnitude into a capped signed Q8.8 value.
module q88_saturate
    import capped_div_pkg::*;
#(
    parameter int unsigned MagW = 24
) (
    input  logic            neg_i,
    input  logic [MagW-1:0] mag_i,
    output logic [15:0]     q_o,
    output logic            ovf_o,
    output logic            unf_o
);

    localparam logic [MagW-1:0] PosLim = MagW'(Q8_8_MAX);
    // Zero-extended 0x8000: the largest magnitude a negative result can take.
    localparam logic [MagW-1:0] NegLim = MagW'(Q8_8_MIN);

    // Select the capped value and the matching flag.
    always_comb begin
        q_o   = 16'h0000;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (mag_i == '0) begin
            q_o = 16'h0000;
        end else if (!neg_i) begin
            if (mag_i > PosLim) begin
                q_o   = Q8_8_MAX;
                ovf_o = 1'b1;
            end else begin
                q_o = mag_i[15:0];
            end
        end else begin
            if (mag_i > NegLim) begin
                q_o   = Q8_8_MIN;
                unf_o = 1'b1;
            end else begin
                // mag == 32768 negates to 0x8000 exactly, without a flag.
                q_o = ~mag_i[15:0] + 16'd1;
            end
        end
    end

endmodule

// File: rtl/capped_div.sv
// Signed Q8.8 divider: restoring division one bit per cycle, result capped to Q8.8.
module capped_div #(
    parameter int unsigned FRACT_BITS = capped_div_pkg::FRACT_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q_out,
    output logic        overflow,
    output logic        underflow_q,
    output logic        div_by_zero
);

    import capped_div_pkg::*;

    // Dividend width: 16-bit magnitude shifted up by the fractional bits.
    localparam int unsigned DivW    = 16 + FRACT_BITS;
    localparam logic [4:0]  LastCnt = 5'(DivW - 1);

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [DivW-1:0]   dvd_q;
    logic [15:0]       dvs_q;
    logic [15:0]       rem_q;
    logic [DivW-1:0]   quot_q;
    logic              neg_q;
    logic [15:0]       q_q;
    logic              ovf_q;
    logic              unf_q;
    logic              dbz_q;

    logic [15:0]       a_mag;
    logic [15:0]       b_mag;
    logic [16:0]       rem_shift;
    logic [16:0]       rem_sub;
    logic              q_bit;
    logic [15:0]       rem_next;
    logic [DivW-1:0]   quot_next;
    logic              last_iter;

    logic [15:0]       sat_q;
    logic              sat_ovf;
    logic              sat_unf;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        a_mag     = abs16(a_in);
        b_mag     = abs16(b_in);
        rem_shift = {rem_q, dvd_q[DivW-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        // Remainder stays below the divisor (<= 32768), so 16 bits always suffice.
        rem_next  = q_bit ? rem_sub[15:0] : rem_shift[15:0];
        quot_next = {quot_q[DivW-2:0], q_bit};
        last_iter = (cnt_q == LastCnt);
    end

    // Saturation sees the quotient including the bit produced this cycle,
    // so the capped result is registered on the same edge that enters DONE.
    q88_saturate #(
        .MagW (DivW)
    ) u_sat (
        .neg_i (neg_q),
        .mag_i (quot_next),
        .q_o   (sat_q),
        .ovf_o (sat_ovf),
        .unf_o (sat_unf)
    );

    // Control FSM together with the datapath and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            dvd_q   <= '0;
            dvs_q   <= 16'h0000;
            rem_q   <= 16'h0000;
            quot_q  <= '0;
            neg_q   <= 1'b0;
            q_q     <= 16'h0000;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        neg_q  <= a_in[15] ^ b_in[15];
                        dvd_q  <= DivW'(a_mag) << FRACT_BITS;
                        dvs_q  <= b_mag;
                        rem_q  <= 16'h0000;
                        quot_q <= '0;
                        cnt_q  <= 5'd0;
                        if (b_in == 16'h0000) begin
                            // Divide by zero: skip CALC, cap toward the dividend's sign.
                            state_q <= StDone;
                            dbz_q   <= 1'b1;
                            if (a_in[15]) begin
                                q_q   <= Q8_8_MIN;
                                ovf_q <= 1'b0;
                                unf_q <= 1'b1;
                            end else begin
                                q_q   <= Q8_8_MAX;
                                ovf_q <= 1'b1;
                                unf_q <= 1'b0;
                            end
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q  <= rem_next;
                    dvd_q  <= dvd_q << 1;
                    quot_q <= quot_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (last_iter) begin
                        state_q <= StDone;
                        q_q     <= sat_q;
                        ovf_q   <= sat_ovf;
                        unf_q   <= sat_unf;
                        dbz_q   <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign q_out       = q_q;
    assign overflow    = ovf_q;
    assign underflow_q = unf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_capped_div.sv
// Directed bench for capped_div: hand-computed quotients, latency, hold and reset.
module tb_capped_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q_out;
    logic        overflow;
    logic        underflow_q;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capped_div #(
        .FRACT_BITS (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q_out       (q_out),
        .overflow    (overflow),
        .underflow_q (underflow_q),
        .div_by_zero (div_by_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation for exactly the accept cycle, then scramble the inputs.
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a_in     = 16'h5A5A;
        b_in     = 16'hA5A5;
    endtask

    // Accept cycle is cycle 0; count cycles until out_valid, bounded.
    task automatic wait_done(input string tag, input int lat_exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    endtask

    task automatic check_res(input string tag, input logic [15:0] q, input logic o,
                             input logic u, input logic d);
        chk({tag, "_q"}, 32'(q_out), 32'(q));
        chk({tag, "_ovf"}, 32'(overflow), 32'(o));
        chk({tag, "_unf"}, 32'(underflow_q), 32'(u));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(d));
    endtask

    // Result handshake with in_valid also high: it must not be accepted on that edge.
    task automatic finish_op(input string tag);
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 16'h0100;
        b_in      = 16'h0100;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_out_valid_post"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] q, input logic o, input logic u, input logic d,
                      input int lat);
        start_op(tag, a, b);
        wait_done(tag, lat);
        check_res(tag, q, o, u, d);
        finish_op(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 16'h0000;
        b_in      = 16'h0000;
        tick();
        tick();
        check_res("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // 3 / 2 = 1.5, then hold the result with out_ready low and in_valid noise.
        start_op("hold", 16'h0300, 16'h0200);
        wait_done("hold", 25);
        check_res("hold", 16'h0180, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        a_in     = 16'h0100;
        b_in     = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_res("hold_stable", 16'h0180, 1'b0, 1'b0, 1'b0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish_op("hold");

        op("neg_half",  16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0, 1'b0, 25);
        op("trunc",     16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 1'b0, 25);
        op("ovf",       16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 1'b0, 25);
        op("min_exact", 16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 1'b0, 25);
        op("unf",       16'h8000, 16'h00FF, 16'h8000, 1'b0, 1'b1, 1'b0, 25);
        op("dbz_pos",   16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1);
        op("dbz_neg",   16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1, 1);
        op("neg_neg",   16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 1'b0, 25);
        op("zero_a",    16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0, 1'b0, 25);
        op("neg_tiny",  16'hFFFF, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0, 25);
        op("one",       16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 25);
        op("neg_small", 16'hFE00, 16'h0100, 16'hFE00, 1'b0, 1'b0, 1'b0, 25);

        // Abort mid-CALC: the previous result (0xFE00) must be wiped by reset.
        start_op("abort", 16'h0300, 16'h0200);
        repeat (11) tick();
        chk("abort_in_calc", 32'(out_valid | in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_res("abort_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_cnt", 32'(dut.cnt_q), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        op("after_abort", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 1'b0, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
